// File: rtl/dmac_write_resp_tracker.sv
// AXI B-channel tracker for the multi-channel DMA write path: per-channel in-flight
// burst accounting, sticky error accumulation, one completion per descriptor.
// Optional statistics counters are enabled with DMAC_WR_RESP_STATS_EN.

module dmac_wrt_chan #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int CNT_WD          = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic push_last,
    input  logic pop,
    input  logic pop_err,
    output logic head_last,
    output logic err_acc,
    output logic full,
    output logic empty,
    output logic busy
);
    logic [CNT_WD-1:0]          cnt, cnt_nxt, wr_idx;
    logic [MAX_OUTSTANDING-1:0] q, q_nxt;

    assign full      = (cnt == CNT_WD'(MAX_OUTSTANDING));
    assign empty     = (cnt == '0);
    assign head_last = q[0];

    // Head sits at bit 0; a pop shifts down first so a same-cycle push lands one slot lower.
    always_comb begin
        cnt_nxt = cnt + CNT_WD'(push) - CNT_WD'(pop);
        wr_idx  = pop ? cnt - 1'b1 : cnt;
        q_nxt   = pop ? (q >> 1) : q;
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (push && (wr_idx == i[CNT_WD-1:0])) q_nxt[i] = push_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            q       <= '0;
            err_acc <= 1'b0;
            busy    <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            q    <= q_nxt;
            busy <= (cnt_nxt != '0);
            if (pop) err_acc <= head_last ? 1'b0 : (err_acc | pop_err);
        end
    end
endmodule

module dmac_write_resp_tracker #(
    parameter int CHANNEL_COUNT   = 8,
    parameter int ID_WD           = $clog2(CHANNEL_COUNT),
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     issue_valid,
    output logic                     issue_ready,
    input  logic [ID_WD-1:0]         issue_chan,
    input  logic                     issue_last,
    input  logic                     m_axi_bvalid,
    input  logic [ID_WD-1:0]         m_axi_bid,
    input  logic [1:0]               m_axi_bresp,
    output logic                     m_axi_bready,
    output logic                     done_valid,
    input  logic                     done_ready,
    output logic [ID_WD-1:0]         done_chan,
    output logic                     done_err,
    output logic                     unexp_resp,
`ifdef DMAC_WR_RESP_STATS_EN
    output logic [15:0]              err_count,
    output logic [7:0]               unexp_count,
`endif
    output logic [CHANNEL_COUNT-1:0] busy
);
    localparam int CNT_WD = $clog2(MAX_OUTSTANDING + 1);

    logic [CHANNEL_COUNT-1:0] issue_hit, bid_hit, push, pop;
    logic [CHANNEL_COUNT-1:0] full, empty, head_last, err_acc;
    logic b_acc, b_known, b_last, b_err, b_err_acc, done_load;
    logic bresp_unused;

    assign bresp_unused = m_axi_bresp[0];

    // Out-of-range channel ids match no channel, so they are never accepted on issue
    // and always count as unexpected on B.
    always_comb begin
        issue_hit = '0;
        bid_hit   = '0;
        for (int c = 0; c < CHANNEL_COUNT; c++) begin
            issue_hit[c] = (issue_chan == ID_WD'(c));
            bid_hit[c]   = (m_axi_bid == ID_WD'(c));
        end
    end

    assign issue_ready  = |(issue_hit & ~full);
    assign push         = issue_hit & ~full & {CHANNEL_COUNT{issue_valid}};

    // B is only taken when the completion register is empty or being drained.
    assign m_axi_bready = !(done_valid && !done_ready);
    assign b_acc        = m_axi_bvalid && m_axi_bready;
    assign b_known      = |(bid_hit & ~empty);
    assign pop          = bid_hit & ~empty & {CHANNEL_COUNT{b_acc}};
    assign b_last       = |(bid_hit & head_last);
    assign b_err_acc    = |(bid_hit & err_acc);
    assign b_err        = m_axi_bresp[1];
    assign done_load    = b_acc && b_known && b_last;

    dmac_wrt_chan #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_WD         (CNT_WD)
    ) u_chan [CHANNEL_COUNT-1:0] (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_last(issue_last),
        .pop      (pop),
        .pop_err  (b_err),
        .head_last(head_last),
        .err_acc  (err_acc),
        .full     (full),
        .empty    (empty),
        .busy     (busy)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_valid <= 1'b0;
            done_chan  <= '0;
            done_err   <= 1'b0;
            unexp_resp <= 1'b0;
        end else begin
            unexp_resp <= b_acc && !b_known;
            if (done_load) begin
                done_valid <= 1'b1;
                done_chan  <= m_axi_bid;
                done_err   <= b_err_acc | b_err;
            end else if (done_ready) begin
                done_valid <= 1'b0;
            end
        end
    end

`ifdef DMAC_WR_RESP_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count   <= '0;
            unexp_count <= '0;
        end else begin
            if (b_acc && b_err && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
            if (b_acc && !b_known && (unexp_count != 8'hFF)) unexp_count <= unexp_count + 8'd1;
        end
    end
`endif
endmodule
